// File: rtl/cpu_regs_wb_ctrl_pkg.sv
// Shared types and constants for the CPU register file and its write-back path.
package cpu_regs_pkg;

    localparam int unsigned CPU_NREGS  = 8;
    localparam int unsigned CPU_REG_AW = 3;
    localparam int unsigned CPU_DW     = 32;

    typedef logic [CPU_REG_AW-1:0] reg_addr_t;
    typedef logic [CPU_DW-1:0]     reg_data_t;

    // Write-back producer identity; also used as the round-robin pointer value.
    typedef enum logic {
        WB_ALU  = 1'b0,
        WB_LOAD = 1'b1
    } wb_src_e;

    // The producer that should be preferred after `s` has been served.
    function automatic wb_src_e wb_other(input wb_src_e s);
        return (s == WB_ALU) ? WB_LOAD : WB_ALU;
    endfunction

endpackage

// File: rtl/cpu_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a tie
// and advances only when a grant is actually consumed (xfer).
module cpu_rr_arb2
    import cpu_regs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       xfer,
    output logic [1:0] gnt
);

    wb_src_e ptr_q;
    wb_src_e ptr_d;
    wb_src_e won;

    // Grant the lone requester, or the pointed-to one when both request.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr_q == WB_ALU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // After a transfer, prefer whichever producer was not just served.
    always_comb begin
        won   = gnt[1] ? WB_LOAD : WB_ALU;
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = wb_other(won);
        end
    end

    // Pointer register; reset favours the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= WB_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cpu_regs_wb_ctrl.sv
// Write-back controller and busy scoreboard for the CPU register file.
// Arbitrates wb0 (ALU) and wb1 (load) onto the single write port with one
// cycle of latency, tracks pending destinations, and flags operand hazards.
// Optional operand forwarding from the in-flight write: CPU_REGS_WB_BYPASS_EN.
module cpu_regs_wb_ctrl
    import cpu_regs_pkg::*;
#(
    parameter int unsigned NREGS = CPU_NREGS,
    parameter int unsigned AW    = CPU_REG_AW,
    parameter int unsigned DW    = CPU_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             claim_valid,
    input  logic [AW-1:0]    claim_addr,
    output logic             claim_ready,
    input  logic             wb0_valid,
    input  logic [AW-1:0]    wb0_addr,
    input  logic [DW-1:0]    wb0_data,
    output logic             wb0_ready,
    input  logic             wb1_valid,
    input  logic [AW-1:0]    wb1_addr,
    input  logic [DW-1:0]    wb1_data,
    output logic             wb1_ready,
    output logic             rf_write_enable,
    output logic [AW-1:0]    rf_write_dest,
    output logic [DW-1:0]    rf_write_data,
    input  logic [AW-1:0]    rd0_addr,
    input  logic [AW-1:0]    rd1_addr,
    output logic             rd0_busy,
    output logic             rd1_busy,
    output logic [NREGS-1:0] busy_vec,
    output logic             wb_orphan
`ifdef CPU_REGS_WB_BYPASS_EN
    ,
    output logic             rd0_fwd_valid,
    output logic [DW-1:0]    rd0_fwd_data,
    output logic             rd1_fwd_valid,
    output logic [DW-1:0]    rd1_fwd_data
`endif
);

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             xfer;

    logic             wen_q;
    logic             wen_d;
    logic [AW-1:0]    dest_q;
    logic [AW-1:0]    dest_d;
    logic [DW-1:0]    data_q;
    logic [DW-1:0]    data_d;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             orphan_q;
    logic             orphan_d;
    logic             claim_fire;

    assign req  = {wb1_valid, wb0_valid};
    assign xfer = |(req & gnt);

    cpu_rr_arb2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .xfer (xfer),
        .gnt  (gnt)
    );

    assign wb0_ready = gnt[0];
    assign wb1_ready = gnt[1];

    // Capture the granted producer's result; dest/data hold when idle.
    always_comb begin
        wen_d  = xfer;
        dest_d = dest_q;
        data_d = data_q;
        if (gnt[0]) begin
            dest_d = wb0_addr;
            data_d = wb0_data;
        end else if (gnt[1]) begin
            dest_d = wb1_addr;
            data_d = wb1_data;
        end
    end

    // Write-port pipeline register; reset drops any in-flight write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q  <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
        end else begin
            wen_q  <= wen_d;
            dest_q <= dest_d;
            data_q <= data_d;
        end
    end

    assign rf_write_enable = wen_q;
    assign rf_write_dest   = dest_q;
    assign rf_write_data   = data_q;

    // A register whose commit is still in flight reads as busy, so a claim on it is refused.
    assign claim_ready = ~busy_q[claim_addr];
    assign claim_fire  = claim_valid & claim_ready;

    // Scoreboard update: commit clears first, then a claim sets, so both land when they differ.
    always_comb begin
        busy_d   = busy_q;
        orphan_d = orphan_q;
        if (wen_q) begin
            busy_d[dest_q] = 1'b0;
            if (!busy_q[dest_q]) begin
                orphan_d = 1'b1;
            end
        end
        if (claim_fire) begin
            busy_d[claim_addr] = 1'b1;
        end
    end

    // Scoreboard and sticky orphan flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q   <= '0;
            orphan_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            orphan_q <= orphan_d;
        end
    end

    assign busy_vec  = busy_q;
    assign wb_orphan = orphan_q;

`ifdef CPU_REGS_WB_BYPASS_EN
    assign rd0_fwd_valid = wen_q & (dest_q == rd0_addr);
    assign rd1_fwd_valid = wen_q & (dest_q == rd1_addr);
    assign rd0_fwd_data  = data_q;
    assign rd1_fwd_data  = data_q;
    assign rd0_busy      = busy_q[rd0_addr] & ~rd0_fwd_valid;
    assign rd1_busy      = busy_q[rd1_addr] & ~rd1_fwd_valid;
`else
    assign rd0_busy      = busy_q[rd0_addr];
    assign rd1_busy      = busy_q[rd1_addr];
`endif

endmodule

// File: tb/tb_cpu_regs_wb_ctrl.sv
// Self-checking bench for cpu_regs_wb_ctrl (build with or without CPU_REGS_WB_BYPASS_EN).
module tb_cpu_regs_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        claim_valid;
    logic [2:0]  claim_addr;
    logic        claim_ready;
    logic        wb0_valid;
    logic [2:0]  wb0_addr;
    logic [31:0] wb0_data;
    logic        wb0_ready;
    logic        wb1_valid;
    logic [2:0]  wb1_addr;
    logic [31:0] wb1_data;
    logic        wb1_ready;
    logic        rf_write_enable;
    logic [2:0]  rf_write_dest;
    logic [31:0] rf_write_data;
    logic [2:0]  rd0_addr;
    logic [2:0]  rd1_addr;
    logic        rd0_busy;
    logic        rd1_busy;
    logic [7:0]  busy_vec;
    logic        wb_orphan;
`ifdef CPU_REGS_WB_BYPASS_EN
    logic        rd0_fwd_valid;
    logic [31:0] rd0_fwd_data;
    logic        rd1_fwd_valid;
    logic [31:0] rd1_fwd_data;
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    cpu_regs_wb_ctrl #(.NREGS(8), .AW(3), .DW(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .claim_valid     (claim_valid),
        .claim_addr      (claim_addr),
        .claim_ready     (claim_ready),
        .wb0_valid       (wb0_valid),
        .wb0_addr        (wb0_addr),
        .wb0_data        (wb0_data),
        .wb0_ready       (wb0_ready),
        .wb1_valid       (wb1_valid),
        .wb1_addr        (wb1_addr),
        .wb1_data        (wb1_data),
        .wb1_ready       (wb1_ready),
        .rf_write_enable (rf_write_enable),
        .rf_write_dest   (rf_write_dest),
        .rf_write_data   (rf_write_data),
        .rd0_addr        (rd0_addr),
        .rd1_addr        (rd1_addr),
        .rd0_busy        (rd0_busy),
        .rd1_busy        (rd1_busy),
        .busy_vec        (busy_vec),
        .wb_orphan       (wb_orphan)
`ifdef CPU_REGS_WB_BYPASS_EN
        ,
        .rd0_fwd_valid   (rd0_fwd_valid),
        .rd0_fwd_data    (rd0_fwd_data),
        .rd1_fwd_valid   (rd1_fwd_valid),
        .rd1_fwd_data    (rd1_fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          cv;
        logic [2:0]  ca;
        bit          w0v;
        logic [2:0]  w0a;
        logic [31:0] w0d;
        bit          w1v;
        logic [2:0]  w1a;
        logic [31:0] w1d;
        logic [2:0]  r0a;
        logic [2:0]  r1a;
        bit          e_cr;
        bit          e_w0r;
        bit          e_w1r;
        bit          e_r0b;
        bit          e_r1b;
        bit          e_orph;
        logic [7:0]  e_busy;
    } vec_t;

    typedef struct {
        logic [2:0]  dest;
        logic [31:0] data;
    } wr_t;

    localparam int NV = 25;
    vec_t        vecs [NV];
    wr_t         exp_q[$];
    logic [2:0]  last_dest;
    logic [31:0] last_data;
    int          n_checks;
    int          n_fail;

    function automatic vec_t mk(bit r, bit cv, int ca,
                                bit w0v, int w0a, logic [31:0] w0d,
                                bit w1v, int w1a, logic [31:0] w1d,
                                int r0a, int r1a,
                                bit cr, bit w0r, bit w1r, bit r0b, bit r1b, bit orph,
                                logic [7:0] busy);
        vec_t v;
        v.rst = r;    v.cv = cv;   v.ca = 3'(ca);
        v.w0v = w0v;  v.w0a = 3'(w0a); v.w0d = w0d;
        v.w1v = w1v;  v.w1a = 3'(w1a); v.w1d = w1d;
        v.r0a = 3'(r0a); v.r1a = 3'(r1a);
        v.e_cr = cr;  v.e_w0r = w0r; v.e_w1r = w1r;
        v.e_r0b = r0b; v.e_r1b = r1b; v.e_orph = orph; v.e_busy = busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        exp_q.delete();
        last_dest = '0;
        last_data = '0;
    endtask

    task automatic idle_inputs();
        claim_valid = 1'b0; claim_addr = '0;
        wb0_valid = 1'b0; wb0_addr = '0; wb0_data = '0;
        wb1_valid = 1'b0; wb1_addr = '0; wb1_data = '0;
        rd0_addr = '0; rd1_addr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        idle_inputs();
        last_dest = '0;
        last_data = '0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;

        //         rst cv ca  w0v a  data          w1v a  data          r0 r1  cr w0 w1 r0b r1b orp busy
        // 1: claim r3, wb0 writes r3, busy drops at commit
        vecs[0]  = mk(1, 1, 3, 0, 0, 32'h0,        0, 0, 32'h0,        3, 0, 1, 0, 0, 0, 0, 0, 8'h00);
        vecs[1]  = mk(0, 0, 3, 1, 3, 32'h12345678, 0, 0, 32'h0,        3, 0, 0, 1, 0, 1, 0, 0, 8'h08);
        vecs[2]  = mk(0, 0, 3, 0, 0, 32'h0,        0, 0, 32'h0,        3, 0, 0, 0, 0, 1, 0, 0, 8'h08);
        vecs[3]  = mk(0, 0, 3, 0, 0, 32'h0,        0, 0, 32'h0,        3, 0, 1, 0, 0, 0, 0, 0, 8'h00);
        // 2: both producers valid four cycles, alternating grants, second writes orphan
        vecs[4]  = mk(1, 1, 1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 1, 0, 0, 0, 0, 0, 8'h00);
        vecs[5]  = mk(0, 1, 2, 0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 1, 0, 0, 1, 0, 0, 8'h02);
        vecs[6]  = mk(0, 0, 2, 1, 1, 32'hA1A1A1A1, 1, 2, 32'hB2B2B2B2, 1, 2, 0, 1, 0, 1, 1, 0, 8'h06);
        vecs[7]  = mk(0, 0, 2, 1, 1, 32'hA3A3A3A3, 1, 2, 32'hB2B2B2B2, 1, 2, 0, 0, 1, 1, 1, 0, 8'h06);
        vecs[8]  = mk(0, 0, 2, 1, 1, 32'hA3A3A3A3, 1, 2, 32'hB4B4B4B4, 1, 2, 0, 1, 0, 0, 1, 0, 8'h04);
        vecs[9]  = mk(0, 0, 2, 1, 1, 32'hA5A5A5A5, 1, 2, 32'hB4B4B4B4, 1, 2, 1, 0, 1, 0, 0, 0, 8'h00);
        vecs[10] = mk(0, 0, 2, 0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 1, 0, 0, 0, 0, 1, 8'h00);
        vecs[11] = mk(0, 0, 2, 0, 0, 32'h0,        0, 0, 32'h0,        1, 2, 1, 0, 0, 0, 0, 1, 8'h00);
        // 3: claim on an already busy register is refused
        vecs[12] = mk(1, 1, 5, 0, 0, 32'h0,        0, 0, 32'h0,        5, 0, 1, 0, 0, 0, 0, 0, 8'h00);
        vecs[13] = mk(0, 1, 5, 0, 0, 32'h0,        0, 0, 32'h0,        5, 0, 0, 0, 0, 1, 0, 0, 8'h20);
        vecs[14] = mk(0, 0, 5, 0, 0, 32'h0,        0, 0, 32'h0,        5, 0, 0, 0, 0, 1, 0, 0, 8'h20);
        // 4: wb1 writes unclaimed r6, orphan becomes sticky
        vecs[15] = mk(0, 0, 5, 0, 0, 32'h0,        1, 6, 32'h00000066, 5, 6, 0, 0, 1, 1, 0, 0, 8'h20);
        vecs[16] = mk(0, 0, 5, 0, 0, 32'h0,        0, 0, 32'h0,        5, 6, 0, 0, 0, 1, 0, 0, 8'h20);
        vecs[17] = mk(0, 0, 5, 0, 0, 32'h0,        0, 0, 32'h0,        5, 6, 0, 0, 0, 1, 0, 1, 8'h20);
        vecs[18] = mk(0, 0, 5, 0, 0, 32'h0,        0, 0, 32'h0,        5, 6, 0, 0, 0, 1, 0, 1, 8'h20);
        // 5: pending r4 read hazard, in-flight claim refused, claim+commit same cycle
        vecs[19] = mk(1, 1, 4, 0, 0, 32'h0,        0, 0, 32'h0,        4, 7, 1, 0, 0, 0, 0, 0, 8'h00);
        vecs[20] = mk(0, 1, 7, 1, 4, 32'hCAFEF00D, 0, 0, 32'h0,        4, 7, 1, 1, 0, 1, 0, 0, 8'h10);
        vecs[21] = mk(0, 1, 4, 0, 0, 32'h0,        0, 0, 32'h0,        4, 7, 0, 0, 0, 1, 1, 0, 8'h90);
        vecs[22] = mk(0, 1, 1, 0, 0, 32'h0,        1, 7, 32'h00000077, 4, 7, 1, 0, 1, 0, 1, 0, 8'h80);
        vecs[23] = mk(0, 1, 2, 0, 0, 32'h0,        0, 0, 32'h0,        4, 7, 1, 0, 0, 0, 1, 0, 8'h82);
        vecs[24] = mk(0, 0, 2, 0, 0, 32'h0,        0, 0, 32'h0,        4, 7, 0, 0, 0, 0, 0, 0, 8'h06);

        for (int i = 0; i < NV; i++) begin
            bit          pend;
            wr_t         pw;
            bit          f0;
            bit          f1;
            @(posedge clk);
            #1;
            if (vecs[i].rst) pulse_reset();
            claim_valid = vecs[i].cv;  claim_addr = vecs[i].ca;
            wb0_valid = vecs[i].w0v;   wb0_addr = vecs[i].w0a; wb0_data = vecs[i].w0d;
            wb1_valid = vecs[i].w1v;   wb1_addr = vecs[i].w1a; wb1_data = vecs[i].w1d;
            rd0_addr = vecs[i].r0a;    rd1_addr = vecs[i].r1a;
            @(negedge clk);
            pend = (exp_q.size() > 0);
            pw.dest = '0;
            pw.data = '0;
            if (pend) begin
                pw = exp_q.pop_front();
                chk($sformatf("v%0d rf_write_enable", i), 32'(rf_write_enable), 32'd1);
                chk($sformatf("v%0d rf_write_dest", i), 32'(rf_write_dest), 32'(pw.dest));
                chk($sformatf("v%0d rf_write_data", i), rf_write_data, pw.data);
                last_dest = pw.dest;
                last_data = pw.data;
            end else begin
                chk($sformatf("v%0d rf_write_enable idle", i), 32'(rf_write_enable), 32'd0);
                chk($sformatf("v%0d rf_write_dest hold", i), 32'(rf_write_dest), 32'(last_dest));
                chk($sformatf("v%0d rf_write_data hold", i), rf_write_data, last_data);
            end
            f0 = BP && pend && (pw.dest == vecs[i].r0a);
            f1 = BP && pend && (pw.dest == vecs[i].r1a);
            chk($sformatf("v%0d claim_ready", i), 32'(claim_ready), 32'(vecs[i].e_cr));
            chk($sformatf("v%0d wb0_ready", i), 32'(wb0_ready), 32'(vecs[i].e_w0r));
            chk($sformatf("v%0d wb1_ready", i), 32'(wb1_ready), 32'(vecs[i].e_w1r));
            chk($sformatf("v%0d busy_vec", i), 32'(busy_vec), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d wb_orphan", i), 32'(wb_orphan), 32'(vecs[i].e_orph));
            chk($sformatf("v%0d rd0_busy", i), 32'(rd0_busy), 32'(vecs[i].e_r0b & ~f0));
            chk($sformatf("v%0d rd1_busy", i), 32'(rd1_busy), 32'(vecs[i].e_r1b & ~f1));
`ifdef CPU_REGS_WB_BYPASS_EN
            chk($sformatf("v%0d rd0_fwd_valid", i), 32'(rd0_fwd_valid), 32'(f0));
            chk($sformatf("v%0d rd1_fwd_valid", i), 32'(rd1_fwd_valid), 32'(f1));
            if (f0) chk($sformatf("v%0d rd0_fwd_data", i), rd0_fwd_data, pw.data);
            if (f1) chk($sformatf("v%0d rd1_fwd_data", i), rd1_fwd_data, pw.data);
`endif
            if (vecs[i].w0v && vecs[i].e_w0r) exp_q.push_back('{dest: vecs[i].w0a, data: vecs[i].w0d});
            if (vecs[i].w1v && vecs[i].e_w1r) exp_q.push_back('{dest: vecs[i].w1a, data: vecs[i].w1d});
        end

        // 6: asynchronous reset mid-cycle right after a transfer
        @(posedge clk);
        #1;
        pulse_reset();
        idle_inputs();
        claim_valid = 1'b1;
        claim_addr  = 3'd3;
        @(negedge clk);
        chk("rst6 claim_ready", 32'(claim_ready), 32'd1);
        @(posedge clk);
        #1;
        claim_valid = 1'b0;
        wb0_valid   = 1'b1;
        wb0_addr    = 3'd3;
        wb0_data    = 32'hDEAD0003;
        @(negedge clk);
        chk("rst6 wb0_ready", 32'(wb0_ready), 32'd1);
        chk("rst6 busy_vec before", 32'(busy_vec), 32'h08);
        @(posedge clk);
        #1;
        wb0_valid = 1'b0;
        chk("rst6 write in flight", 32'(rf_write_enable), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst6 async wen", 32'(rf_write_enable), 32'd0);
        chk("rst6 async busy_vec", 32'(busy_vec), 32'd0);
        chk("rst6 async dest", 32'(rf_write_dest), 32'd0);
        chk("rst6 async data", rf_write_data, 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst6 no commit wen", 32'(rf_write_enable), 32'd0);
        chk("rst6 no commit busy", 32'(busy_vec), 32'd0);
        chk("rst6 no commit orphan", 32'(wb_orphan), 32'd0);
        @(posedge clk);
        #1;
        wb0_valid = 1'b1; wb0_addr = 3'd5; wb0_data = 32'h55;
        wb1_valid = 1'b1; wb1_addr = 3'd6; wb1_data = 32'h66;
        @(negedge clk);
        chk("rst6 ptr wb0_ready", 32'(wb0_ready), 32'd1);
        chk("rst6 ptr wb1_ready", 32'(wb1_ready), 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
